// File: rtl/pc_pkg.sv
// Shared types for the PC fetch unit and its branch target buffer.
package pc_pkg;

    // Widest PC supported by the BTB entry fields; narrower PCs are zero-extended.
    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ  = 2'b00,
        PCSRC_BR   = 2'b01,
        PCSRC_JALR = 2'b10,
        PCSRC_RSVD = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control, execute-feedback and fetch-output bundle of the PC fetch unit.
interface pc_fetch_unit_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     trigger;
    logic                     halt;
    logic                     stall;
    logic                     ex_valid;
    logic [1:0]               pcsrc;
    logic [ADDRESS_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0]    immext;
    logic [DATA_WIDTH-1:0]    result;
    logic                     ex_pred_taken;
    logic [ADDRESS_WIDTH-1:0] ex_pred_target;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pcplus4;
    logic                     fetch_valid;
    logic                     pred_taken;
    logic [ADDRESS_WIDTH-1:0] pred_target;
    logic                     flush;

    modport master (
        output trigger, halt, stall, ex_valid, pcsrc, ex_pc, immext, result,
               ex_pred_taken, ex_pred_target,
        input  pc, pcplus4, fetch_valid, pred_taken, pred_target, flush
    );

    modport slave (
        input  trigger, halt, stall, ex_valid, pcsrc, ex_pc, immext, result,
               ex_pred_taken, ex_pred_target,
        output pc, pcplus4, fetch_valid, pred_taken, pred_target, flush
    );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, clocked update.
module pc_btb
    import pc_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned BTB_DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] rd_pc,
    output logic                     pred_taken,
    output logic [ADDRESS_WIDTH-1:0] pred_target,
    input  logic                     upd_valid,
    input  logic                     upd_taken,
    input  logic [ADDRESS_WIDTH-1:0] upd_pc,
    input  logic [ADDRESS_WIDTH-1:0] upd_target
);
    localparam int unsigned AW    = ADDRESS_WIDTH;
    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned SH    = IDX_W + 2;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [PC_W-1:0]      tag_q [BTB_DEPTH];
    logic [PC_W-1:0]      tgt_q [BTB_DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [PC_W-1:0]  rd_tag;
    logic [PC_W-1:0]  upd_tag;
    btb_entry_t       rd_entry;
    btb_entry_t       wr_entry;
    logic             wr_en;
    logic             clr_en;

    assign rd_idx  = rd_pc[SH-1:2];
    assign upd_idx = upd_pc[SH-1:2];
    assign rd_tag  = PC_W'(rd_pc >> SH);
    assign upd_tag = PC_W'(upd_pc >> SH);

    // Lookup reads registered storage only, so a same-cycle write is not visible.
    always_comb begin
        rd_entry.valid  = valid_q[rd_idx];
        rd_entry.tag    = tag_q[rd_idx];
        rd_entry.target = tgt_q[rd_idx];
        pred_taken      = rd_entry.valid && (rd_entry.tag == rd_tag);
        pred_target     = AW'(rd_entry.target);
    end

    // Taken branches allocate; a not-taken branch evicts its own matching entry.
    always_comb begin
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = upd_tag;
        wr_entry.target = PC_W'(upd_target);
        wr_en           = upd_valid && upd_taken;
        clr_en          = upd_valid && !upd_taken && (tag_q[upd_idx] == upd_tag);
    end

    // Valid bits are the only reset state; stale tag/target data is harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[upd_idx] <= wr_entry.valid;
        end else if (clr_en) begin
            valid_q[upd_idx] <= 1'b0;
        end
    end

    // Tag/target payload storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[upd_idx] <= wr_entry.tag;
            tgt_q[upd_idx] <= wr_entry.target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC generator: run-control FSM, branch resolution and next-PC select.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned BTB_DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    pc_fetch_unit_if.slave bus
);
    localparam int unsigned AW = ADDRESS_WIDTH;

    fetch_state_e   state_q;
    fetch_state_e   state_d;
    pcsrc_e         pcsrc;
    logic [AW-1:0]  pc_q;
    logic [AW-1:0]  pc_d;
    logic [AW-1:0]  pcplus4;
    logic [AW-1:0]  jalr_raw;
    logic [AW-1:0]  act_target;
    logic           act_taken;
    logic           mispredict;
    logic           run;
    logic           pred_taken;
    logic [AW-1:0]  pred_target;

    assign pcsrc    = pcsrc_e'(bus.pcsrc);
    assign pcplus4  = pc_q + AW'(4);
    assign jalr_raw = AW'(bus.result);

    pc_btb #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .BTB_DEPTH     (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_pc       (pc_q),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (bus.ex_valid),
        .upd_taken   (act_taken),
        .upd_pc      (bus.ex_pc),
        .upd_target  (act_target)
    );

    // Resolve the execute-stage branch and compare against the fetch-time prediction.
    always_comb begin
        act_taken  = 1'b0;
        act_target = bus.ex_pc + AW'(4);
        case (pcsrc)
            PCSRC_BR: begin
                act_taken  = 1'b1;
                act_target = bus.ex_pc + AW'(bus.immext);
            end
            PCSRC_JALR: begin
                act_taken  = 1'b1;
                act_target = {jalr_raw[AW-1:1], 1'b0};
            end
            default: ;
        endcase
        mispredict = bus.ex_valid &&
                     ((act_taken != bus.ex_pred_taken) ||
                      (act_taken && bus.ex_pred_taken && (act_target != bus.ex_pred_target)));
    end

    // Run-control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run-control transitions; halt wins over trigger.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!bus.halt && bus.trigger) state_d = ST_RUN;
            ST_RUN:  if (bus.halt)                 state_d = ST_HALT;
            ST_HALT: if (!bus.halt && bus.trigger) state_d = ST_RUN;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Run-control decoded outputs.
    always_comb begin
        run = 1'b0;
        if (state_q == ST_RUN) run = 1'b1;
    end

    // Next-PC priority: redirect, stall, not running, predicted, sequential.
    always_comb begin
        pc_d = pcplus4;
        if (mispredict) begin
            pc_d = act_taken ? act_target : (bus.ex_pc + AW'(4));
        end else if (bus.stall || !run) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pcplus4     = pcplus4;
    assign bus.fetch_valid = run;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign bus.flush       = mispredict;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL take parameter ADDRESS_WIDTH, default 32, meaning the PC width.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, meaning the immext/result width (equal to ADDRESS_WIDTH).
REQ-003 The block SHALL take parameter RESET_VECTOR, default 0, meaning the PC loaded at reset.
REQ-004 The block SHALL take parameter BTB_DEPTH, default 16, meaning the BTB entry count (power of 2, >=2).
REQ-005 The block SHALL use one clock `clk` and an asynchronous, active-low reset `rst`.
REQ-006 The ports SHALL be:
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- trigger  in  1  start/resume fetch.
- halt  in  1  stop fetch.
- stall  in  1  hold PC.
- ex_valid  in  1  execute-stage instruction valid.
- pcsrc  in  2  00 seq, 01 branch/jal taken, 10 jalr, 11 treated as 00.
- ex_pc  in  ADDRESS_WIDTH  PC of the execute-stage instruction.
- immext  in  DATA_WIDTH  branch/jal offset.
- result  in  DATA_WIDTH  jalr target.
- ex_pred_taken  in  1  prediction made at fetch.
- ex_pred_target  in  ADDRESS_WIDTH  predicted target.
- pc  out  ADDRESS_WIDTH  fetch address.
- pcplus4  out  ADDRESS_WIDTH  pc+4.
- fetch_valid  out  1  pc is a real fetch.
- pred_taken  out  1  BTB hit for pc.
- pred_target  out  ADDRESS_WIDTH  BTB target for pc.
- flush  out  1  mispredict; kill younger stages.

Function
REQ-007 FSM states SHALL be IDLE, RUN and HALT; IDLE->RUN on trigger=1; RUN->HALT on halt=1; HALT->RUN on trigger=1; halt takes priority over trigger in the same cycle.
REQ-008 fetch_valid SHALL be 1 only in RUN.
REQ-009 Actual target SHALL be ex_pc+immext for pcsrc=01, and result with bit0 cleared for pcsrc=10.
REQ-010 Actual-taken SHALL be 1 when pcsrc is 01 or 10.
REQ-011 A mispredict SHALL occur when ex_valid=1 and either actual-taken != ex_pred_taken, or both are taken with target != ex_pred_target.
REQ-012 flush SHALL equal the mispredict condition combinationally, in any state.
REQ-013 Next-PC priority, highest first: mispredict (actual target if taken, else ex_pc+4) > stall (hold) > not RUN (hold) > pred_taken (pred_target) > pcplus4.
REQ-014 A mispredict redirect SHALL update pc in IDLE and HALT as well, without changing state.
REQ-015 pc SHALL update on the clock edge following the decision; redirect latency is 1 cycle.
REQ-016 All PC arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH; 'hFFFFFFFC+4 = 0.
REQ-017 BTB SHALL be direct-mapped, indexed by pc[log2(BTB_DEPTH)+1:2], with entries {valid, tag = remaining upper bits, target}.
REQ-018 BTB lookup SHALL be combinational from registered storage; pred_taken = entry valid and tag match.
REQ-019 When ex_valid=1 and actual-taken=1, the BTB SHALL write {1, tag(ex_pc), target} at the clock edge.
REQ-020 When ex_valid=1, pcsrc=00 and the entry tag matches ex_pc, the BTB SHALL clear that entry's valid bit.
REQ-021 A same-cycle read and write of one index SHALL return the old entry.
REQ-022 A BTB update SHALL occur even while stall=1.

Reset
REQ-023 While rst=0, the block SHALL set pc=RESET_VECTOR, state=IDLE, all BTB valid bits=0, fetch_valid=0 and pred_taken=0; pcplus4=RESET_VECTOR+4.
REQ-024 Reset asserted mid-operation SHALL discard any pending redirect and BTB write.

Structure
REQ-025 Package pc_pkg SHALL hold the pcsrc enum, the fetch-state enum and the btb_entry_t struct (parametrised widths passed through as localparams of the package user).
REQ-026 BTB storage and lookup SHALL live in one sub-module, pc_btb; FSM and next-PC selection SHALL remain in pc_fetch_unit.

Verification
REQ-027 Reset release, trigger=0 for 3 cycles -> pc=0, fetch_valid=0; trigger=1 -> next cycles pc=0,4,8 with fetch_valid=1.
REQ-028 ex_valid=1, pcsrc=01, ex_pc='h10, immext='h40, ex_pred_taken=0 -> flush=1 that cycle, pc='h50 next cycle, BTB entry for 'h10 written; second pass at pc='h10 -> pred_taken=1, pred_target='h50, next pc='h50, no flush.
REQ-029 jalr with pcsrc=10, result='h1235 -> next pc='h1234.
REQ-030 stall=1 with a simultaneous mispredict (target 'h80) -> pc='h80 next cycle; stall=1 with no mispredict -> pc unchanged.
REQ-031 halt=1 then trigger=1 at pc='h20 -> pc held at 'h20 in HALT, fetch resumes 'h20,'h24 after trigger; rst pulsed mid-run -> pc=RESET_VECTOR and pred_taken=0 everywhere.
